// File: rtl/vga_buffer_writer.sv
// Frame-buffer write engine: accepts draw commands and sweeps full-screen clears. A command write appears one cycle after it is accepted.
// Backpressure: cmd_ready is low while a clear is requested or in progress, and out-of-range commands are dropped with an oob pulse.
`ifndef VGA_H_BITS
`define VGA_H_BITS 7
`endif
`ifndef VGA_V_BITS
`define VGA_V_BITS 9
`endif
`ifndef VGA_COLS
`define VGA_COLS 80
`endif
`ifndef VGA_ROWS
`define VGA_ROWS 480
`endif
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module vga_buffer_writer #(
    parameter int H_BITS = `VGA_H_BITS,
    parameter int V_BITS = `VGA_V_BITS,
    parameter int COLS   = `VGA_COLS,
    parameter int ROWS   = `VGA_ROWS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [H_BITS-1:0]       cmd_x,
    input  logic [V_BITS-1:0]       cmd_y,
    input  logic [`BYTE_BITS-1:0]   cmd_byte,
    input  logic                    clr_req,
    input  logic [`BYTE_BITS-1:0]   clr_byte,
    output logic                    busy,
    output logic                    clr_done,
    output logic                    oob,
    output logic                    wr_en,
    output logic [H_BITS-1:0]       wr_x,
    output logic [V_BITS-1:0]       wr_y,
    output logic [`BYTE_BITS-1:0]   byte_in
);

    localparam logic [H_BITS-1:0] LAST_X = H_BITS'(COLS - 1);
    localparam logic [V_BITS-1:0] LAST_Y = V_BITS'(ROWS - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  r_state;
    logic [H_BITS-1:0]       r_cnt_x;
    logic [V_BITS-1:0]       r_cnt_y;
    logic [`BYTE_BITS-1:0]   r_fill;
    logic                    r_wr_en;
    logic [H_BITS-1:0]       r_wr_x;
    logic [V_BITS-1:0]       r_wr_y;
    logic [`BYTE_BITS-1:0]   r_byte;
    logic                    r_busy;
    logic                    r_clr_done;
    logic                    r_oob;

    logic [H_BITS-1:0]       w_nx;
    logic [V_BITS-1:0]       w_ny;
    logic                    w_cnt_last;
    logic                    w_nx_last;
    logic                    w_in_range;

    assign cmd_ready = (r_state == S_IDLE) & ~clr_req;

    // Widen before comparing so COLS/ROWS beyond the coordinate width still work.
    assign w_in_range = (32'(cmd_x) < 32'(COLS)) && (32'(cmd_y) < 32'(ROWS));

    always_comb begin
        w_nx = r_cnt_x + 1'b1;
        w_ny = r_cnt_y;
        if (r_cnt_x == LAST_X) begin
            w_nx = '0;
            w_ny = r_cnt_y + 1'b1;
        end
        w_cnt_last = (r_cnt_x == LAST_X) && (r_cnt_y == LAST_Y);
        w_nx_last  = (w_nx == LAST_X) && (w_ny == LAST_Y);
    end

    // Counters hold the position currently on the write port during CLEAR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt_x    <= '0;
            r_cnt_y    <= '0;
            r_fill     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_x     <= '0;
            r_wr_y     <= '0;
            r_byte     <= '0;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b0;
            r_oob      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_oob      <= 1'b0;
                    r_clr_done <= 1'b0;
                    r_busy     <= 1'b0;
                    r_wr_en    <= 1'b0;
                    if (clr_req) begin
                        r_state    <= S_CLEAR;
                        r_fill     <= clr_byte;
                        r_cnt_x    <= '0;
                        r_cnt_y    <= '0;
                        r_wr_en    <= 1'b1;
                        r_wr_x     <= '0;
                        r_wr_y     <= '0;
                        r_byte     <= clr_byte;
                        r_busy     <= 1'b1;
                        r_clr_done <= (LAST_X == '0) && (LAST_Y == '0);
                    end else if (cmd_valid && cmd_ready) begin
                        if (w_in_range) begin
                            r_wr_en <= 1'b1;
                            r_wr_x  <= cmd_x;
                            r_wr_y  <= cmd_y;
                            r_byte  <= cmd_byte;
                        end else begin
                            r_oob   <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_oob <= 1'b0;
                    if (w_cnt_last) begin
                        r_state    <= S_IDLE;
                        r_wr_en    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_clr_done <= 1'b0;
                    end else begin
                        r_cnt_x    <= w_nx;
                        r_cnt_y    <= w_ny;
                        r_wr_en    <= 1'b1;
                        r_wr_x     <= w_nx;
                        r_wr_y     <= w_ny;
                        r_byte     <= r_fill;
                        r_busy     <= 1'b1;
                        r_clr_done <= w_nx_last;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_done = r_clr_done;
    assign oob      = r_oob;
    assign wr_en    = r_wr_en;
    assign wr_x     = r_wr_x;
    assign wr_y     = r_wr_y;
    assign byte_in  = r_byte;

endmodule

// File: tb/tb_vga_buffer_writer.sv
// Directed bench for vga_buffer_writer on a 4x3 buffer with 3-bit x and 2-bit y coordinates.
module tb_vga_buffer_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_x;
    logic [1:0] cmd_y;
    logic [7:0] cmd_byte;
    logic       clr_req;
    logic [7:0] clr_byte;
    logic       busy;
    logic       clr_done;
    logic       oob;
    logic       wr_en;
    logic [2:0] wr_x;
    logic [1:0] wr_y;
    logic [7:0] byte_in;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_buffer_writer #(.H_BITS(3), .V_BITS(2), .COLS(4), .ROWS(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_byte(cmd_byte),
        .clr_req(clr_req), .clr_byte(clr_byte),
        .busy(busy), .clr_done(clr_done), .oob(oob),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .byte_in(byte_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [2:0] x, input logic [1:0] y, input logic [7:0] d);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, "_wr_x"}, 32'(wr_x), 32'(x));
        chk({tag, "_wr_y"}, 32'(wr_y), 32'(y));
        chk({tag, "_byte"}, 32'(byte_in), 32'(d));
        chk({tag, "_oob"}, 32'(oob), 32'd0);
    endtask

    task automatic chk_drop(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_oob"}, 32'(oob), 32'd1);
    endtask

    task automatic send(input logic [2:0] x, input logic [1:0] y, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_x     = x;
        cmd_y     = y;
        cmd_byte  = d;
    endtask

    task automatic chk_sweep(input string tag, input logic [7:0] fill);
        for (int i = 0; i < 12; i++) begin
            chk_write(tag, 3'(i % 4), 2'(i / 4), fill);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
            chk({tag, "_done"}, 32'(clr_done), (i == 11) ? 32'd1 : 32'd0);
            step();
        end
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_byte = '0;
        clr_req = 1'b0; clr_byte = '0;

        // Reset asserted mid-cycle, held three edges, released mid-cycle
        #3 reset = 1'b1;
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_wr_x", 32'(wr_x), 32'd0);
        chk("rst_wr_y", 32'(wr_y), 32'd0);
        chk("rst_byte", 32'(byte_in), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        chk("rst_oob", 32'(oob), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // Single write
        step();
        send(3'd3, 2'd2, 8'hA5);
        #1 chk("single_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        chk_write("single", 3'd3, 2'd2, 8'hA5);
        step();
        chk("single_after", 32'(wr_en), 32'd0);

        // Back-to-back with out-of-range commands in between
        send(3'd0, 2'd0, 8'h01);
        step();
        chk_write("b2b0", 3'd0, 2'd0, 8'h01);
        send(3'd4, 2'd0, 8'h02);
        step();
        chk_drop("b2b1");
        send(3'd1, 2'd3, 8'h03);
        step();
        chk_drop("b2b2");
        send(3'd3, 2'd2, 8'h04);
        step();
        chk_write("b2b3", 3'd3, 2'd2, 8'h04);
        send(3'd5, 2'd2, 8'h06);
        step();
        chk_drop("b2b4");
        cmd_valid = 1'b0;
        step();
        chk("b2b_idle_wr", 32'(wr_en), 32'd0);
        chk("b2b_idle_oob", 32'(oob), 32'd0);

        // Clear sweep
        clr_byte = 8'hFF;
        clr_req  = 1'b1;
        #1 chk("clr_ready_req", 32'(cmd_ready), 32'd0);
        step();
        clr_req  = 1'b0;
        clr_byte = 8'h00;
        chk_sweep("clr", 8'hFF);
        chk("clr_end_wr", 32'(wr_en), 32'd0);
        chk("clr_end_busy", 32'(busy), 32'd0);
        chk("clr_end_done", 32'(clr_done), 32'd0);
        chk("clr_end_ready", 32'(cmd_ready), 32'd1);

        // Clear has priority over a simultaneous command
        clr_byte = 8'h3C;
        clr_req  = 1'b1;
        send(3'd1, 2'd1, 8'h77);
        #1 chk("pri_ready", 32'(cmd_ready), 32'd0);
        step();
        clr_req = 1'b0;
        chk_sweep("pri", 8'h3C);
        chk("pri_idle_wr", 32'(wr_en), 32'd0);
        chk("pri_idle_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        chk_write("pri_cmd", 3'd1, 2'd1, 8'h77);
        step();
        chk("pri_after", 32'(wr_en), 32'd0);

        // Held clear request restarts a sweep
        clr_byte = 8'h5A;
        clr_req  = 1'b1;
        step();
        chk_sweep("held", 8'h5A);
        chk("held_gap_wr", 32'(wr_en), 32'd0);
        chk("held_gap_ready", 32'(cmd_ready), 32'd0);
        step();
        clr_req = 1'b0;
        chk_write("held_first", 3'd0, 2'd0, 8'h5A);
        chk("held_busy", 32'(busy), 32'd1);

        // Reset during the 5th write of that sweep
        repeat (4) step();
        chk_write("mid5", 3'd0, 2'd1, 8'h5A);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_wr", 32'(wr_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(clr_done), 32'd0);
        step();
        #2 reset = 1'b0;
        #1 chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("mid_quiet_wr", 32'(wr_en), 32'd0);
            chk("mid_quiet_busy", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
